// File: rtl/match_arbiter_pkg.sv
// Shared definitions for the match arbiter: state codes, attack sizing, target search, clamping.
// Latency: none (constants and pure functions only).
// Backpressure: not applicable.
package match_arbiter_pkg;

  // Round sequencing states, encoded as they appear on match_state
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_COUNT = 2'd1;
  localparam logic [1:0] ST_PLAY  = 2'd2;
  localparam logic [1:0] ST_OVER  = 2'd3;

  // A single attack is at most 4 rows; the sum of all attacks into one
  // player (up to 7 sources) is at most 28 rows.
  localparam int ATK_W = 3;
  localparam int ACC_W = 6;

  // Rows of garbage produced by clearing the given number of lines
  function automatic logic [ATK_W-1:0] attack_size(input logic [2:0] lines);
    case (lines)
      3'd2:    return 3'd1;
      3'd3:    return 3'd2;
      3'd4:    return 3'd4;
      default: return 3'd0;
    endcase
  endfunction

  // First alive player after src, wrapping, never src itself; -1 when none
  function automatic int next_target(input logic [7:0] alive_v, input int src, input int n);
    int idx;
    for (int k = 1; k < n; k++) begin
      idx = src + k;
      if (idx >= n) idx = idx - n;
      if (alive_v[idx]) return idx;
    end
    return -1;
  endfunction

  // a + b clamped into [0, max_val]; b may be negative
  function automatic int sat_add(input int a, input int b, input int max_val);
    int s;
    s = a + b;
    if (s < 0) return 0;
    if (s > max_val) return max_val;
    return s;
  endfunction

endpackage

// File: rtl/match_arbiter_if.sv
// Bundles the game-side handshake and status signals of the match arbiter.
// Latency: none (wiring only).
// Backpressure: garbage is pulled by the game with garb_ack against garb_req.
interface match_arbiter_if #(
  parameter int N_PLAYERS = 2,
  parameter int GARB_W    = 4,
  parameter int WIN_W     = 4
);
  logic                        start;
  logic [N_PLAYERS-1:0]        fail;
  logic [N_PLAYERS-1:0]        clear_valid;
  logic [3*N_PLAYERS-1:0]      clear_lines;
  logic [N_PLAYERS-1:0]        garb_ack;
  logic [N_PLAYERS-1:0]        run;
  logic [N_PLAYERS-1:0]        garb_req;
  logic [GARB_W*N_PLAYERS-1:0] garb_pending;
  logic [N_PLAYERS-1:0]        alive;
  logic [N_PLAYERS-1:0]        winner;
  logic [1:0]                  match_state;
  logic [WIN_W*N_PLAYERS-1:0]  wins;

  // Arbiter side: drives run/garbage/status, receives game events
  modport master (
    input  start, fail, clear_valid, clear_lines, garb_ack,
    output run, garb_req, garb_pending, alive, winner, match_state, wins
  );

  // Game side: drives events, receives run/garbage/status
  modport slave (
    output start, fail, clear_valid, clear_lines, garb_ack,
    input  run, garb_req, garb_pending, alive, winner, match_state, wins
  );
endinterface

// File: rtl/match_arbiter_garbage_queue.sv
// Per-player pending-garbage counter with netted add/subtract and saturation at both ends.
// Latency: add/sub/clear visible on count one cycle later.
// Backpressure: req stays high while rows are pending; the game drains one row per ack.
module garbage_queue
  import match_arbiter_pkg::*;
#(
  parameter int GARB_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              clear,
  input  logic [ACC_W-1:0]  add_amt,
  input  logic [ACC_W-1:0]  sub_amt,
  output logic              req,
  output logic [GARB_W-1:0] count
);
  localparam int MAX_CNT = (1 << GARB_W) - 1;

  int next_val;

  // Net incoming rows against removed rows at full width, then clamp
  always_comb begin
    next_val = sat_add(int'(count), int'(add_amt) - int'(sub_amt), MAX_CNT);
  end

  // Clear wins over any add so a dead player never keeps garbage
  always_ff @(posedge clk or posedge rst) begin
    if (rst)        count <= '0;
    else if (clear) count <= '0;
    else            count <= GARB_W'(next_val);
  end

  assign req = en && (count != '0);
endmodule

// File: rtl/match_arbiter.sv
// N-player match controller: round FSM, alive tracking, garbage routing, win tallies.
// Latency: clear pulse to garb_pending 1 cycle; fail to alive 1 cycle; last survivor to OVER 1 further cycle.
// Backpressure: garbage waits in per-player queues until acked; MATCH_ATTACK_CANCEL_EN lets attacks cancel own pending first.
module match_arbiter
  import match_arbiter_pkg::*;
#(
  parameter int N_PLAYERS    = 2,
  parameter int GARB_W       = 4,
  parameter int WIN_W        = 4,
  parameter int COUNT_CYCLES = 300000000
) (
  input logic            clk,
  input logic            rst,
  match_arbiter_if.master m
);
  localparam int CNT_W   = (COUNT_CYCLES > 1) ? $clog2(COUNT_CYCLES) : 1;
  localparam int WIN_MAX = (1 << WIN_W) - 1;

  logic [1:0]           state_q;
  logic [CNT_W-1:0]     cnt_q;
  logic                 start_q;
  logic [N_PLAYERS-1:0] alive_q;
  logic [N_PLAYERS-1:0] winner_q;
  logic [WIN_W-1:0]     wins_q [N_PLAYERS];

  logic                 start_rise;
  logic                 in_play;
  logic                 new_round;
  logic                 round_end;

  logic [GARB_W-1:0]    pend      [N_PLAYERS];
  logic [N_PLAYERS-1:0] req_w;
  logic [N_PLAYERS-1:0] q_clear;
  logic [ACC_W-1:0]     q_add     [N_PLAYERS];
  logic [ACC_W-1:0]     q_sub     [N_PLAYERS];

  int atk_amt    [N_PLAYERS];
  int cancel_amt [N_PLAYERS];
  int send_amt   [N_PLAYERS];
  int tgt_idx    [N_PLAYERS];
  int add_sum    [N_PLAYERS];

  assign start_rise = m.start & ~start_q;
  assign in_play    = (state_q == ST_PLAY);
  assign new_round  = start_rise && ((state_q == ST_IDLE) || (state_q == ST_OVER));
  // A lone player's round only ends when it tops out
  assign round_end  = in_play &&
                      ((N_PLAYERS == 1) ? ($countones(alive_q) == 0) : ($countones(alive_q) <= 1));

  // Round sequencing, alive tracking and winner capture
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      start_q  <= 1'b0;
      alive_q  <= '1;
      winner_q <= '0;
    end else begin
      start_q <= m.start;
      case (state_q)
        ST_IDLE, ST_OVER: begin
          if (start_rise) begin
            state_q  <= ST_COUNT;
            cnt_q    <= CNT_W'(COUNT_CYCLES - 1);
            alive_q  <= '1;
            winner_q <= '0;
          end
        end
        ST_COUNT: begin
          if (cnt_q == '0) state_q <= ST_PLAY;
          else             cnt_q   <= cnt_q - 1'b1;
        end
        default: begin
          alive_q <= alive_q & ~m.fail;
          if (round_end) begin
            state_q  <= ST_OVER;
            winner_q <= alive_q;
          end
        end
      endcase
    end
  end

  // Credit the surviving player when the round closes; tallies survive new rounds
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N_PLAYERS; i++) wins_q[i] <= '0;
    end else if (round_end) begin
      for (int i = 0; i < N_PLAYERS; i++)
        if (alive_q[i]) wins_q[i] <= WIN_W'(sat_add(int'(wins_q[i]), 1, WIN_MAX));
    end
  end

  // Size each live attack, optionally cancel own garbage, and route the rest
  always_comb begin
    for (int i = 0; i < N_PLAYERS; i++) begin
      atk_amt[i]    = 0;
      cancel_amt[i] = 0;
      send_amt[i]   = 0;
      tgt_idx[i]    = -1;
      add_sum[i]    = 0;
    end
    for (int i = 0; i < N_PLAYERS; i++) begin
      if (in_play && m.clear_valid[i] && alive_q[i])
        atk_amt[i] = int'(attack_size(m.clear_lines[3*i +: 3]));
`ifdef MATCH_ATTACK_CANCEL_EN
      cancel_amt[i] = (int'(pend[i]) < atk_amt[i]) ? int'(pend[i]) : atk_amt[i];
`endif
      send_amt[i] = atk_amt[i] - cancel_amt[i];
      tgt_idx[i]  = next_target(8'(alive_q), i, N_PLAYERS);
    end
    for (int t = 0; t < N_PLAYERS; t++)
      for (int i = 0; i < N_PLAYERS; i++)
        if (tgt_idx[i] == t) add_sum[t] = add_sum[t] + send_amt[i];
  end

  // Per-queue controls: ack only counts against a live request, cancel precedes it
  always_comb begin
    for (int i = 0; i < N_PLAYERS; i++) begin
      q_add[i]   = ACC_W'(add_sum[i]);
      q_sub[i]   = ACC_W'(cancel_amt[i] + int'(m.garb_ack[i] & req_w[i]));
      q_clear[i] = new_round || (in_play && m.fail[i] && alive_q[i]);
    end
  end

  for (genvar g = 0; g < N_PLAYERS; g++) begin : g_player
    garbage_queue #(.GARB_W(GARB_W)) u_queue (
      .clk     (clk),
      .rst     (rst),
      .en      (in_play && alive_q[g]),
      .clear   (q_clear[g]),
      .add_amt (q_add[g]),
      .sub_amt (q_sub[g]),
      .req     (req_w[g]),
      .count   (pend[g])
    );
    assign m.garb_pending[GARB_W*g +: GARB_W] = pend[g];
    assign m.wins[WIN_W*g +: WIN_W]           = wins_q[g];
  end

  assign m.run         = in_play ? alive_q : '0;
  assign m.garb_req    = req_w;
  assign m.alive       = alive_q;
  assign m.winner      = winner_q;
  assign m.match_state = state_q;
endmodule

// File: tb/tb_match_arbiter.sv
// Directed bench for match_arbiter: a 2-player and a 3-player instance with a 4-cycle countdown.
// Latency: inputs driven 1 time unit after a rising edge, outputs checked at the same point.
// Backpressure: garbage drained by explicit ack vectors.
module tb_match_arbiter;
  logic clk;
  logic rst;
  int   checks;
  int   errors;

  match_arbiter_if #(.N_PLAYERS(2), .GARB_W(4), .WIN_W(4)) a_if ();
  match_arbiter_if #(.N_PLAYERS(3), .GARB_W(4), .WIN_W(4)) b_if ();

  match_arbiter #(.N_PLAYERS(2), .GARB_W(4), .WIN_W(4), .COUNT_CYCLES(4)) dut_a (
    .clk (clk), .rst (rst), .m (a_if)
  );
  match_arbiter #(.N_PLAYERS(3), .GARB_W(4), .WIN_W(4), .COUNT_CYCLES(4)) dut_b (
    .clk (clk), .rst (rst), .m (b_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    a_if.start = 1'b0; a_if.fail = '0; a_if.clear_valid = '0; a_if.clear_lines = '0; a_if.garb_ack = '0;
    b_if.start = 1'b0; b_if.fail = '0; b_if.clear_valid = '0; b_if.clear_lines = '0; b_if.garb_ack = '0;

    // Reset values
    tick();
    check("rst_state",   a_if.match_state, 2'd0);
    check("rst_run",     a_if.run, 2'b00);
    check("rst_req",     a_if.garb_req, 2'b00);
    check("rst_pending", a_if.garb_pending, 8'h00);
    check("rst_alive",   a_if.alive, 2'b11);
    check("rst_winner",  a_if.winner, 2'b00);
    check("rst_wins",    a_if.wins, 8'h00);
    rst = 1'b0;

    // Start edge enters countdown
    a_if.start = 1'b1;
    tick();
    check("cnt_enter", a_if.match_state, 2'd1);
    a_if.start = 1'b0;
    // Clear during countdown is ignored
    a_if.clear_valid = 2'b01; a_if.clear_lines = {3'd0, 3'd4};
    tick();
    check("cnt_clear_ignored", a_if.garb_pending, 8'h00);
    a_if.clear_valid = 2'b00;
    tick();
    tick();
    check("cnt_still", a_if.match_state, 2'd1);
    tick();
    check("play_enter", a_if.match_state, 2'd2);
    check("play_run",   a_if.run, 2'b11);

    // Tetris from player 0 sends 4 rows to player 1
    a_if.clear_valid = 2'b01; a_if.clear_lines = {3'd0, 3'd4};
    tick();
    a_if.clear_valid = 2'b00;
    check("atk4_pending", a_if.garb_pending, 8'h40);
    check("atk4_req",     a_if.garb_req, 2'b10);
    a_if.garb_ack = 2'b10;
    tick();
    check("ack1_pending", a_if.garb_pending, 8'h30);
    tick(); tick(); tick();
    check("ack4_pending", a_if.garb_pending, 8'h00);
    check("ack4_req",     a_if.garb_req, 2'b00);
    tick();
    check("ack_no_underflow", a_if.garb_pending, 8'h00);
    a_if.garb_ack = 2'b00;

    // Build pending[0]=3 from player 1, then player 0 clears 4 lines
    a_if.clear_valid = 2'b10; a_if.clear_lines = {3'd3, 3'd0};
    tick();
    a_if.clear_lines = {3'd2, 3'd0};
    tick();
    check("p0_pending3", a_if.garb_pending, 8'h03);
    check("p0_req",      a_if.garb_req, 2'b01);
    a_if.clear_valid = 2'b01; a_if.clear_lines = {3'd0, 3'd4};
    tick();
    a_if.clear_valid = 2'b00;
`ifdef MATCH_ATTACK_CANCEL_EN
    check("cancel_pending", a_if.garb_pending, 8'h10);
`else
    check("nocancel_pending", a_if.garb_pending, 8'h43);
`endif
    a_if.garb_ack = 2'b11;
    tick(); tick(); tick(); tick();
    check("drain_both", a_if.garb_pending, 8'h00);
    a_if.garb_ack = 2'b00;

    // Saturation: 4+4+4+2 = 14, then +2-1 clamps to 15, then +4 stays 15
    a_if.clear_valid = 2'b01; a_if.clear_lines = {3'd0, 3'd4};
    tick(); tick(); tick();
    a_if.clear_lines = {3'd0, 3'd3};
    tick();
    check("pend14", a_if.garb_pending, 8'he0);
    a_if.garb_ack = 2'b10;
    tick();
    check("pend_net_sat", a_if.garb_pending, 8'hf0);
    a_if.garb_ack = 2'b00; a_if.clear_lines = {3'd0, 3'd4};
    tick();
    check("pend_hold_max", a_if.garb_pending, 8'hf0);
    a_if.clear_valid = 2'b00;

    // Both players top out together: draw
    a_if.fail = 2'b11;
    tick();
    check("draw_alive",   a_if.alive, 2'b00);
    check("draw_pending", a_if.garb_pending, 8'h00);
    check("draw_state1",  a_if.match_state, 2'd2);
    check("draw_run",     a_if.run, 2'b00);
    tick();
    check("draw_over",   a_if.match_state, 2'd3);
    check("draw_winner", a_if.winner, 2'b00);
    check("draw_wins",   a_if.wins, 8'h00);
    a_if.fail = 2'b00;
    a_if.clear_valid = 2'b01; a_if.clear_lines = {3'd0, 3'd4};
    tick();
    check("over_clear_ignored", a_if.garb_pending, 8'h00);
    a_if.clear_valid = 2'b00;
    a_if.start = 1'b1;
    tick();
    check("restart_state", a_if.match_state, 2'd1);
    check("restart_alive", a_if.alive, 2'b11);
    a_if.start = 1'b0;

    // Three players: start, count down, play
    b_if.start = 1'b1;
    tick();
    check("b_count", b_if.match_state, 2'd1);
    b_if.start = 1'b0;
    tick(); tick(); tick(); tick();
    check("b_play", b_if.match_state, 2'd2);
    check("b_run",  b_if.run, 3'b111);
    b_if.fail = 3'b100;
    tick();
    check("b_alive_011", b_if.alive, 3'b011);
    check("b_run_011",   b_if.run, 3'b011);
    b_if.clear_valid = 3'b001; b_if.clear_lines = 9'b000_000_010;
    tick();
    check("b_atk_to_p1", b_if.garb_pending, 12'h010);
    // Player 1 attack skips dead player 2 and wraps to player 0
    b_if.clear_valid = 3'b010; b_if.clear_lines = 9'b000_100_000;
    tick();
`ifdef MATCH_ATTACK_CANCEL_EN
    check("b_wrap", b_if.garb_pending, 12'h003);
`else
    check("b_wrap", b_if.garb_pending, 12'h014);
`endif
    b_if.clear_valid = 3'b100; b_if.clear_lines = 9'b100_000_000;
    tick();
`ifdef MATCH_ATTACK_CANCEL_EN
    check("b_dead_src", b_if.garb_pending, 12'h003);
`else
    check("b_dead_src", b_if.garb_pending, 12'h014);
`endif
    b_if.clear_valid = 3'b000;
    b_if.fail = 3'b110;
    tick();
    check("b_alive_001", b_if.alive, 3'b001);
`ifdef MATCH_ATTACK_CANCEL_EN
    check("b_dead_cleared", b_if.garb_pending, 12'h003);
`else
    check("b_dead_cleared", b_if.garb_pending, 12'h004);
`endif
    tick();
    check("b_over",   b_if.match_state, 2'd3);
    check("b_winner", b_if.winner, 3'b001);
    check("b_wins",   b_if.wins, 12'h001);
    check("b_run0",   b_if.run, 3'b000);
    check("b_req0",   b_if.garb_req, 3'b000);
    b_if.fail = 3'b000;

    // Asynchronous reset between clock edges
    #2;
    rst = 1'b1;
    #2;
    check("arst_a_state", a_if.match_state, 2'd0);
    check("arst_a_alive", a_if.alive, 2'b11);
    check("arst_b_wins",  b_if.wins, 12'h000);
    check("arst_b_pend",  b_if.garb_pending, 12'h000);
    check("arst_b_win",   b_if.winner, 3'b000);
    rst = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
